zx_tape_fastload: RTL and testbench

- Parametrised fast tape loader for the ZX80/ZX81 core; generalises the inline loader into a standalone block.
- Traps the ROM LOAD entry on an M1 fetch and substitutes a spin-loop patch for the ROM bytes.
- While the CPU spins, it streams the tape buffer into main RAM, then releases the CPU through the patch.
- Adds over the inline loader: selectable file format/offset, a zero-length case, abort on buffer reload, byte counter and done pulse.

---
 rtl/zx_tape_fastload_if.sv | 36 +++
 rtl/zx_tape_fastload.sv | 189 ++++++++++++++++++
 tb/tb_zx_tape_fastload.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/zx_tape_fastload_if.sv
// Bus bundle between the ZX80/ZX81 system side (master) and the tape fast loader (slave).
`timescale 1ns/1ps
`default_nettype none

interface zx_tape_fastload_if #(
    parameter int ADDR_W = 14
);
    logic              ce_cpu;
    logic              zx81;
    logic              fmt;
    logic              m1_n;
    logic [15:0]       cpu_addr;
    logic              tape_valid;
    logic [ADDR_W:0]   tape_len;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_din;
    logic [15:0]       ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic              active;
    logic [7:0]        patch_dout;
    logic [ADDR_W:0]   count;
    logic              done;

    modport master (
        output ce_cpu, zx81, fmt, m1_n, cpu_addr, tape_valid, tape_len, buf_din,
        input  buf_addr, ram_addr, ram_din, ram_we, active, patch_dout, count, done
    );

    modport slave (
        input  ce_cpu, zx81, fmt, m1_n, cpu_addr, tape_valid, tape_len, buf_din,
        output buf_addr, ram_addr, ram_din, ram_we, active, patch_dout, count, done
    );
endinterface

`default_nettype wire

// File: rtl/zx_tape_fastload.sv
// ---------------------------------------------------------------------------
// zx_tape_fastload : traps ROM LOAD, spins the CPU on a patch and streams the
//                    tape buffer into RAM. Option macro: TAPE_AUTOREWIND_EN.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module zx_tape_fastload #(
    parameter int          ADDR_W    = 14,
    parameter logic [15:0] DEST_BASE = 16'h4000,
    parameter logic [15:0] OFFS_O    = 16'd0,
    parameter logic [15:0] OFFS_P    = 16'd9,
    parameter logic [15:0] TRAP81    = 16'h0347,
    parameter logic [15:0] END81     = 16'h03C3,
    parameter logic [15:0] TRAP80    = 16'h0207,
    parameter logic [15:0] END80     = 16'h024D,
    parameter logic [15:0] JP81      = 16'h0207,
    parameter logic [15:0] JP80      = 16'h0203
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    zx_tape_fastload_if.slave  bus
);

    localparam logic [ADDR_W:0] c_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE     = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_FETCH = 3'd2,
        S_WRITE = 3'd3,
        S_SPIN  = 3'd4
    } state_t;

    state_t            r_state, w_state_nx;
    logic              r_m1_n, r_active, r_zx81, r_fmt, r_consumed;
    logic [ADDR_W:0]   r_count, r_len;
    logic [ADDR_W-1:0] r_buf_addr;

    logic              w_zx81, w_m1_fall, w_exit, w_hit;
    logic [15:0]       w_trap, w_end, w_jp, w_idx, w_cnt16;
    logic [ADDR_W:0]   w_len, w_count_inc;
    logic              w_we, w_done, w_start, w_fetch, w_release, w_consume;
    logic [7:0]        w_patch;

    // Live machine selection until the trap fires, latched copy afterwards.
    assign w_zx81      = (r_state == S_IDLE || r_state == S_READY) ? bus.zx81 : r_zx81;
    assign w_trap      = w_zx81 ? TRAP81 : TRAP80;
    assign w_end       = w_zx81 ? END81  : END80;
    assign w_jp        = w_zx81 ? JP81   : JP80;
    assign w_m1_fall   = r_m1_n & ~bus.m1_n;
    assign w_hit       = w_m1_fall && (bus.cpu_addr == w_trap);
    assign w_exit      = w_m1_fall && ((bus.cpu_addr < w_trap) || (bus.cpu_addr >= w_end));
    assign w_len       = (bus.tape_len > c_MAX_LEN) ? c_MAX_LEN : bus.tape_len;
    assign w_count_inc = r_count + c_ONE;
    assign w_cnt16     = 16'(r_count);
    assign w_idx       = bus.cpu_addr - w_trap;

    always_comb begin
        w_state_nx = r_state;
        w_we       = 1'b0;
        w_done     = 1'b0;
        w_start    = 1'b0;
        w_fetch    = 1'b0;
        w_release  = 1'b0;
        w_consume  = 1'b0;
        if (r_state != S_IDLE && !bus.tape_valid) begin
            w_state_nx = S_IDLE;
            w_release  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.tape_valid && !r_consumed) w_state_nx = S_READY;
                end
                S_READY: begin
                    if (w_hit) begin
                        w_start    = 1'b1;
                        w_state_nx = (w_len != '0) ? S_FETCH : S_SPIN;
                    end
                end
                S_FETCH: begin
                    if (w_exit) begin
                        w_state_nx = S_IDLE;
                        w_release  = 1'b1;
                        w_consume  = 1'b1;
                    end else if (bus.ce_cpu) begin
                        w_fetch    = 1'b1;
                        w_state_nx = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_exit) begin
                        w_state_nx = S_IDLE;
                        w_release  = 1'b1;
                        w_consume  = 1'b1;
                    end else begin
                        w_we = 1'b1;
                        if (w_count_inc == r_len) begin
                            w_done     = 1'b1;
                            w_state_nx = S_SPIN;
                        end else begin
                            w_state_nx = S_FETCH;
                        end
                    end
                end
                S_SPIN: begin
                    if (w_exit) begin
                        w_release  = 1'b1;
`ifdef TAPE_AUTOREWIND_EN
                        w_state_nx = S_READY;
`else
                        w_state_nx = S_IDLE;
                        w_consume  = 1'b1;
`endif
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // The buffer address is kept one step ahead so buf_din is settled by WRITE.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_m1_n     <= 1'b1;
            r_active   <= 1'b0;
            r_zx81     <= 1'b0;
            r_fmt      <= 1'b0;
            r_consumed <= 1'b0;
            r_count    <= '0;
            r_len      <= '0;
            r_buf_addr <= '0;
        end else begin
            r_m1_n <= bus.m1_n;
            if (!bus.tape_valid) r_consumed <= 1'b0;
            else if (w_consume)  r_consumed <= 1'b1;
            if (w_start) begin
                r_active   <= 1'b1;
                r_count    <= '0;
                r_len      <= w_len;
                r_zx81     <= bus.zx81;
                r_fmt      <= bus.fmt;
                r_buf_addr <= '0;
            end
            if (w_fetch) r_buf_addr <= r_count[ADDR_W-1:0];
            if (w_we) begin
                r_count    <= w_count_inc;
                r_buf_addr <= w_count_inc[ADDR_W-1:0];
            end
            if (w_release) r_active <= 1'b0;
        end
    end

    // Patch: xor a / nop|scf / jr nc,-3 / jp target -- spins until carry is set.
    always_comb begin
        w_patch = 8'h00;
        if (r_active) begin
            case (w_idx)
                16'd0:   w_patch = 8'hAF;
                16'd1:   w_patch = (r_state == S_SPIN) ? 8'h37 : 8'h00;
                16'd2:   w_patch = 8'h30;
                16'd3:   w_patch = 8'hFD;
                16'd4:   w_patch = 8'hC3;
                16'd5:   w_patch = w_jp[7:0];
                16'd6:   w_patch = w_jp[15:8];
                default: w_patch = 8'h00;
            endcase
        end
    end

    assign bus.buf_addr   = r_buf_addr;
    assign bus.ram_we     = w_we;
    assign bus.ram_addr   = w_we ? (DEST_BASE + (r_fmt ? OFFS_P : OFFS_O) + w_cnt16) : 16'h0000;
    assign bus.ram_din    = w_we ? bus.buf_din : 8'h00;
    assign bus.active     = r_active;
    assign bus.patch_dout = w_patch;
    assign bus.count      = r_count;
    assign bus.done       = w_done;

endmodule

`default_nettype wire

// File: tb/tb_zx_tape_fastload.sv
// ---------------------------------------------------------------------------
// tb_zx_tape_fastload : randomized self-checking bench for zx_tape_fastload.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_zx_tape_fastload;
    localparam int AW   = 4;
    localparam int NBUF = 16;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b1;

    zx_tape_fastload_if #(.ADDR_W(AW)) bus ();

    zx_tape_fastload #(.ADDR_W(AW)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] tape_mem [NBUF];
    always @(posedge clk_sys) bus.buf_din <= tape_mem[bus.buf_addr];

    // Observed RAM writes and done pulses
    int          n_we = 0, n_done = 0, done_at = -1;
    logic [15:0] wq_a [$];
    logic [7:0]  wq_d [$];
    always @(negedge clk_sys) begin
        if (bus.ram_we === 1'b1) begin
            n_we++;
            wq_a.push_back(bus.ram_addr);
            wq_d.push_back(bus.ram_din);
        end
        if (bus.done === 1'b1) begin
            n_done++;
            done_at = n_we;
        end
    end

    initial begin
        bus.ce_cpu = 1'b0;
        forever begin
            repeat (3) @(posedge clk_sys);
            #1 bus.ce_cpu = 1'b1;
            @(posedge clk_sys);
            #1 bus.ce_cpu = 1'b0;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic m1_at(input logic [15:0] a);
        bus.cpu_addr = a;
        bus.m1_n     = 1'b0;
        cyc(1);
        bus.m1_n     = 1'b1;
        cyc(1);
    endtask

    function automatic logic [15:0] trap_of(input bit z);
        return z ? 16'h0347 : 16'h0207;
    endfunction

    function automatic logic [15:0] end_of(input bit z);
        return z ? 16'h03C3 : 16'h024D;
    endfunction

    function automatic logic [7:0] patch_ref(input int k, input bit z, input bit spin);
        case (k)
            0:       return 8'hAF;
            1:       return spin ? 8'h37 : 8'h00;
            2:       return 8'h30;
            3:       return 8'hFD;
            4:       return 8'hC3;
            5:       return z ? 8'h07 : 8'h03;
            6:       return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < NBUF; i++) tape_mem[i] = 8'($urandom);
    endtask

    task automatic wait_writes(input int base, input int n);
        for (int t = 0; t < 300 && (n_we - base) < n; t++) cyc(1);
    endtask

    // Byte i of the file lands at dest+i with the buffer byte i.
    task automatic check_writes(input int base, input int n, input logic [15:0] dest);
        check_eq("wr_count", n_we - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < wq_a.size()) begin
                check_eq("wr_addr", wq_a[base + i], 16'(dest + 16'(i)));
                check_eq("wr_data", wq_d[base + i], tape_mem[i]);
            end
        end
    endtask

    task automatic arm(input bit z, input bit f, input int len);
        bus.tape_valid = 1'b0;
        cyc(2);
        bus.zx81       = z;
        bus.fmt        = f;
        bus.tape_len   = 5'(len);
        bus.tape_valid = 1'b1;
        cyc(2);
    endtask

    task automatic do_load(input bit z, input bit f, input int len,
                           input logic [15:0] exit_a, input bit flip);
        int          exp_n, base, dbase;
        logic [15:0] trap, dest;
        trap  = trap_of(z);
        exp_n = (len > NBUF) ? NBUF : len;
        dest  = 16'h4000 + (f ? 16'd9 : 16'd0);
        arm(z, f, len);
        base  = n_we;
        dbase = n_done;
        m1_at(trap);
        check_eq("active_on", bus.active, 1'b1);
        if (flip) begin
            bus.zx81 = ~z;
            bus.fmt  = ~f;
        end
        bus.cpu_addr = trap + 16'd1;
        #1;
        check_eq("patch_p1_early", bus.patch_dout, (exp_n > 0) ? 8'h00 : 8'h37);
        m1_at(trap);
        wait_writes(base, exp_n);
        cyc(3);
        check_writes(base, exp_n, dest);
        check_eq("done_count", n_done - dbase, (exp_n > 0) ? 1 : 0);
        if (exp_n > 0) check_eq("done_on_last", done_at, base + exp_n);
        check_eq("count", bus.count, exp_n);
        cyc(1);
        for (int k = 0; k < 8; k++) begin
            bus.cpu_addr = trap + 16'(k);
            #1;
            check_eq("patch", bus.patch_dout, patch_ref(k, z, 1'b1));
        end
        cyc(1);
        m1_at(end_of(z) - 16'd1);
        check_eq("still_active", bus.active, 1'b1);
        m1_at(exit_a);
        check_eq("active_off", bus.active, 1'b0);
        check_eq("count_held", bus.count, exp_n);
        bus.zx81 = z;
        bus.fmt  = f;
    endtask

    initial begin
        int base, dbase;
        bit z, f;
        bus.m1_n       = 1'b1;
        bus.cpu_addr   = 16'h0347;
        bus.tape_valid = 1'b0;
        bus.tape_len   = '0;
        bus.zx81       = 1'b1;
        bus.fmt        = 1'b0;
        fill_rand();
        #1 reset_n = 1'b0;
        cyc(2);
        check_eq("rst_active", bus.active, 1'b0);
        check_eq("rst_we", bus.ram_we, 1'b0);
        check_eq("rst_count", bus.count, 0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_buf_addr", bus.buf_addr, 0);
        check_eq("rst_ram_addr", bus.ram_addr, 0);
        check_eq("rst_ram_din", bus.ram_din, 0);
        check_eq("rst_patch", bus.patch_dout, 0);
        reset_n = 1'b1;
        cyc(2);

        // ZX81 .p, 11 22 33, then a second LOAD with the tape still present
        tape_mem[0] = 8'h11; tape_mem[1] = 8'h22; tape_mem[2] = 8'h33;
        do_load(1'b1, 1'b1, 3, 16'h03C3, 1'b0);
        base = n_we;
        m1_at(16'h0347);
        wait_writes(base, 3);
        cyc(4);
`ifdef TAPE_AUTOREWIND_EN
        check_writes(base, 3, 16'h4009);
        check_eq("reload_active", bus.active, 1'b1);
        m1_at(16'h03C3);
        check_eq("reload_exit", bus.active, 1'b0);
`else
        check_eq("rearm_active", bus.active, 1'b0);
        check_eq("rearm_writes", n_we - base, 0);
`endif

        fill_rand();
        do_load(1'b0, 1'b0, 2, 16'h0250, 1'b0);
        do_load(1'b1, 1'b0, 0, 16'h0346, 1'b0);
        fill_rand();
        do_load(1'b0, 1'b1, 20, 16'h024D, 1'b1);

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            z = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
            do_load(z, f, $urandom_range(1, 16),
                    ($urandom_range(0, 1) == 0) ? trap_of(z) - 16'd1 : end_of(z),
                    1'($urandom_range(0, 1)));
        end

        // Abort after the 2nd of 5 writes
        fill_rand();
        arm(1'b1, 1'b0, 5);
        base  = n_we;
        dbase = n_done;
        m1_at(16'h0347);
        wait_writes(base, 2);
        bus.tape_valid = 1'b0;
        cyc(1);
        check_eq("abort_active", bus.active, 1'b0);
        check_eq("abort_count", bus.count, 2);
        cyc(20);
        check_eq("abort_writes", n_we - base, 2);
        check_eq("abort_done", n_done - dbase, 0);

        // Asynchronous reset in the middle of a write
        arm(1'b1, 1'b0, 5);
        m1_at(16'h0347);
        for (int t = 0; t < 100 && bus.ram_we !== 1'b1; t++) cyc(1);
        check_eq("rst_mid_we_seen", bus.ram_we, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_mid_we", bus.ram_we, 1'b0);
        check_eq("rst_mid_active", bus.active, 1'b0);
        check_eq("rst_mid_count", bus.count, 0);
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        check_eq("rst_after_active", bus.active, 1'b0);
        bus.tape_valid = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
